bit_stream_arbiter: RTL and testbench
=====================================

BIT_STREAM_ARBITER -- requirements
Module: bit_stream_arbiter

Interface
REQ-001 Parameter FRAME_LEN, default 8, is the beats per granted frame; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  per-requester request for the shared serial channel.
REQ-005 bit_in  input  4  per-requester serial data bit; only the granted lane is sampled.
REQ-006 gnt  output  4  registered one-hot grant; all zero when no frame is active.
REQ-007 busy  output  1  high while state is RUN.
REQ-008 ser_out  output  1  Mealy output: bit_in of the granted lane while in RUN, else 0.
REQ-009 ones_cnt  output  2  modulo-4 count of 1 bits seen in the current or last frame.
REQ-010 frame_done  output  1  one-cycle pulse marking completion of a full frame.
REQ-011 done_id  output  2  index of the lane whose frame completed or aborted; holds until the next completion.
REQ-012 abort  output  1  one-cycle pulse marking a frame aborted (see REQ-027).

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and GAP.
REQ-014 IDLE with req==0 SHALL stay in IDLE.
REQ-015 IDLE with any req bit set SHALL select a winner and enter RUN on the next edge.
- gnt becomes one-hot for the winner in the same edge.
- Grant latency is 1 cycle from req sampled in IDLE.
REQ-016 Winner selection SHALL be round-robin.
- Search the lanes starting at ptr, ascending, wrapping 3->0.
- The first lane with req set wins.
REQ-017 ptr SHALL update to (winner+1) mod 4 when a grant is issued.
REQ-018 Entering RUN SHALL clear the beat counter and ones_cnt to 0.
REQ-019 In RUN, ser_out SHALL equal bit_in[winner] combinationally, in the same cycle.
REQ-020 In RUN, each cycle with bit_in[winner]==1 SHALL increment ones_cnt modulo 4 (3 wraps to 0).
REQ-021 RUN SHALL last exactly FRAME_LEN cycles; on beat FRAME_LEN-1 the next state is GAP.
REQ-022 Entering GAP after a full frame SHALL:
- clear gnt to 0;
- assert frame_done for the single GAP cycle;
- load done_id with the winner.
REQ-023 GAP SHALL last one cycle, then enter IDLE unconditionally.
- Back-to-back frames are therefore separated by 2 non-RUN cycles (GAP, IDLE).
REQ-024 ones_cnt SHALL hold its final frame value through GAP and IDLE until the next RUN entry.
REQ-025 Request changes by non-granted lanes during RUN SHALL have no effect; they are evaluated in the next IDLE.
REQ-026 Simultaneous requests SHALL be resolved solely by REQ-016; no lane may win twice consecutively while another lane is requesting.

Reset
REQ-027 reset SHALL force the following on the next edge, overriding any state including mid-frame:
- state=IDLE, gnt=0, ptr=0, beat counter=0;
- ones_cnt=0, done_id=0, frame_done=0, abort=0.
- No frame_done or abort pulse results from a reset-terminated frame.
REQ-028 While reset is high, ser_out SHALL be 0 and busy SHALL be 0.

Configuration
REQ-029 Macro BIT_STREAM_ARBITER_ABORT_EN enables frame abort.
- Defined: in RUN, req[winner]==0 forces ser_out=0 and suppresses the ones_cnt update that cycle.
- Defined: the next state is GAP, with abort=1 (not frame_done) for that cycle and done_id=winner.
- Undefined: req[winner] is ignored after grant, the frame always runs FRAME_LEN beats, and abort is tied to 0.

Verification
REQ-030 Round-robin: FRAME_LEN=8, req=4'b1111 held -> grants lane 0,1,2,3,0 in order; each gnt lasts 8 cycles; the next gnt follows 2 cycles after the prior RUN ends.
REQ-031 Count wrap: lane 2 alone, bit_in[2]=1 for all 8 beats -> ser_out high for 8 cycles, ones_cnt sequence 1,2,3,0,1,2,3,0, then frame_done=1 with done_id=2 and ones_cnt=0.
REQ-032 Pointer fairness: frame on lane 3 completes, then req=4'b1001 -> lane 0 wins (ptr wrapped to 0); a following req=4'b1001 -> lane 3 wins.
REQ-033 Reset mid-frame: reset at beat 4 of a lane-1 frame -> next cycle gnt=0, busy=0, ones_cnt=0, no frame_done; the next grant searches from lane 0.
REQ-034 Abort, macro defined: lane 1 drops req at beat 3 -> ser_out=0 that cycle, abort pulses 1 cycle with done_id=1, no frame_done. Macro undefined: the frame completes all 8 beats and abort stays 0.
REQ-035 Idle hold: req=0 for 20 cycles after reset -> gnt=0, busy=0, ser_out=0, no pulses.

Source files
------------

// File: rtl/bit_stream_arbiter.sv
// ---------------------------------------------------------------------------
// bit_stream_arbiter
//
// Round-robin arbiter that hands a shared serial channel to one of four
// requesters for a fixed-length frame of FRAME_LEN beats. While a lane holds
// the grant, its serial bit is forwarded to ser_out and the number of 1 bits
// in the frame is counted modulo 4. A one-cycle GAP state separates frames.
//
// Optional feature:
//   BIT_STREAM_ARBITER_ABORT_EN - when defined, a granted lane that drops its
//   request mid-frame aborts the frame (abort pulse instead of frame_done).
//   When undefined, the request is ignored after grant and abort is tied 0.
//
// Ports:
//   clk        - single clock, rising-edge active
//   reset      - synchronous, active-high reset
//   req        - [3:0] per-lane request
//   bit_in     - [3:0] per-lane serial data bit
//   gnt        - [3:0] registered one-hot grant, zero outside a frame
//   busy       - high while a frame is running
//   ser_out    - bit_in of the granted lane while running, else 0
//   ones_cnt   - [1:0] modulo-4 count of 1 bits in the current/last frame
//   frame_done - one-cycle pulse on completion of a full frame
//   done_id    - [1:0] lane of the last completed or aborted frame
//   abort      - one-cycle pulse on an aborted frame
// ---------------------------------------------------------------------------
module bit_stream_arbiter #(
    parameter int FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] bit_in,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       ser_out,
    output logic [1:0] ones_cnt,
    output logic       frame_done,
    output logic [1:0] done_id,
    output logic       abort
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [3:0] LAST_BEAT = 4'(FRAME_LEN - 1);

    state_e     state_q;
    logic [3:0] gnt_q;
    logic [1:0] win_q;
    logic [1:0] ptr_q;
    logic [3:0] beat_q;
    logic [1:0] ones_q;
    logic [1:0] done_id_q;
    logic       frame_done_q;

    logic [1:0] win_d;
    logic       found_d;
    logic [1:0] idx;
    logic       lane_bit;
    logic       drop;

    // Round-robin search: first requesting lane at or after ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so
        // no path leaves it unassigned, which would otherwise infer a latch.
        win_d   = ptr_q;
        found_d = 1'b0;
        idx     = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found_d && req[idx]) begin
                win_d   = idx;
                found_d = 1'b1;
            end
        end
    end

    assign lane_bit = bit_in[win_q];

`ifdef BIT_STREAM_ARBITER_ABORT_EN
    logic abort_q;
    // Granted lane withdrew its request: the frame ends this cycle.
    assign drop  = (state_q == RUN) && !req[win_q];
    assign abort = abort_q;
`else
    assign drop  = 1'b0;
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all sequential state, so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= IDLE;
            gnt_q        <= 4'b0;
            win_q        <= 2'd0;
            ptr_q        <= 2'd0;
            beat_q       <= 4'd0;
            ones_q       <= 2'd0;
            done_id_q    <= 2'd0;
            frame_done_q <= 1'b0;
`ifdef BIT_STREAM_ARBITER_ABORT_EN
            abort_q      <= 1'b0;
`endif
        end else begin
            // Pulses are high only in the cycle after the event that sets them.
            frame_done_q <= 1'b0;
`ifdef BIT_STREAM_ARBITER_ABORT_EN
            abort_q      <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q <= RUN;
                        gnt_q   <= 4'b0001 << win_d;
                        win_q   <= win_d;
                        ptr_q   <= win_d + 2'd1;
                        beat_q  <= 4'd0;
                        ones_q  <= 2'd0;
                    end
                end
                RUN: begin
                    if (drop) begin
                        // Aborted beat is not counted.
                        state_q   <= GAP;
                        gnt_q     <= 4'b0;
                        done_id_q <= win_q;
`ifdef BIT_STREAM_ARBITER_ABORT_EN
                        abort_q   <= 1'b1;
`endif
                    end else begin
                        if (lane_bit) begin
                            ones_q <= ones_q + 2'd1;
                        end
                        if (beat_q == LAST_BEAT) begin
                            state_q      <= GAP;
                            gnt_q        <= 4'b0;
                            frame_done_q <= 1'b1;
                            done_id_q    <= win_q;
                        end else begin
                            beat_q <= beat_q + 4'd1;
                        end
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // busy and ser_out are forced low combinationally while reset is asserted.
    assign busy       = (state_q == RUN) && !reset;
    assign ser_out    = busy && lane_bit && !drop;
    assign gnt        = gnt_q;
    assign ones_cnt   = ones_q;
    assign frame_done = frame_done_q;
    assign done_id    = done_id_q;

endmodule

// File: tb/tb_bit_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bit_stream_arbiter
//
// Directed stimulus with a scoreboard: expected grant / completion / abort
// events are queued by the stimulus and popped by an independent monitor.
// Per-beat ser_out, gnt and ones_cnt are checked inside the frame driver.
// ---------------------------------------------------------------------------
module tb_bit_stream_arbiter;

    localparam int FL = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] bit_in;
    logic [3:0] gnt;
    logic       busy;
    logic       ser_out;
    logic [1:0] ones_cnt;
    logic       frame_done;
    logic [1:0] done_id;
    logic       abort;

    bit_stream_arbiter #(.FRAME_LEN(FL)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .bit_in     (bit_in),
        .gnt        (gnt),
        .busy       (busy),
        .ser_out    (ser_out),
        .ones_cnt   (ones_cnt),
        .frame_done (frame_done),
        .done_id    (done_id),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_GRANT = 0, EV_DONE = 1, EV_ABORT = 2} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       lane;
        int       ones;
    } ev_t;

    ev_t        exp_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [3:0] prev_gnt = 4'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input ev_kind_e k, input int lane, input int ones);
        ev_t e;
        e.kind = k;
        e.lane = lane;
        e.ones = ones;
        exp_q.push_back(e);
    endtask

    task automatic take_event(input ev_kind_e k);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected event", int'(k), -1);
            return;
        end
        e = exp_q.pop_front();
        check("event kind", int'(k), int'(e.kind));
        if (k == EV_GRANT) begin
            check("grant lane", int'(gnt), 1 << e.lane);
        end else begin
            check("done_id", int'(done_id), e.lane);
            check("ones_cnt at frame end", int'(ones_cnt), e.ones);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents an event.
    always @(negedge clk) begin
        if (!reset) begin
            if (gnt != 4'b0 && prev_gnt == 4'b0) take_event(EV_GRANT);
            if (frame_done) take_event(EV_DONE);
            if (abort) take_event(EV_ABORT);
        end
        prev_gnt = gnt;
    end

    // Waits (bounded) for the first RUN cycle; returns negedges advanced.
    task automatic wait_busy(output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!busy && waited < 40);
        check("grant arrives", int'(busy), 1);
    endtask

    // Drives one frame on `lane` with per-beat bit pattern `pat` (other lanes
    // held at 1), checking ser_out, gnt and the running ones count each beat.
    // Returns at the GAP negedge.
    task automatic run_frame(input int lane, input logic [15:0] pat,
                             output int waited, output int beats);
        int         ones;
        logic [3:0] oh;
        logic       b;
        ones = 0;
        oh   = 4'b0001 << lane;
        wait_busy(waited);
        beats = 0;
        while (busy && beats < 20) begin
            b      = (beats < 16) ? pat[beats] : 1'b0;
            bit_in = ~oh | (b ? oh : 4'b0);
            #1;
            check("ser_out", int'(ser_out), int'(b));
            check("gnt during frame", int'(gnt), int'(oh));
            check("ones_cnt running", int'(ones_cnt), ones % 4);
            ones += int'(b);
            @(negedge clk);
            beats++;
        end
        check("gnt cleared in GAP", int'(gnt), 0);
    endtask

    int waited;
    int beats;
    int bad;
    int rr_lane[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset  = 1'b1;
        req    = 4'b0;
        bit_in = 4'hF;
        repeat (3) @(negedge clk);
        check("reset gnt", int'(gnt), 0);
        check("reset busy", int'(busy), 0);
        check("reset ser_out", int'(ser_out), 0);
        check("reset ones_cnt", int'(ones_cnt), 0);
        check("reset done_id", int'(done_id), 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset abort", int'(abort), 0);
        reset = 1'b0;

        // Idle hold: no requests for 20 cycles.
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (gnt != 4'b0 || busy || ser_out || frame_done || abort) bad++;
        end
        check("idle hold bad cycles", bad, 0);

        // Round-robin with all lanes requesting: 0,1,2,3,0.
        bit_in = 4'b0;
        foreach (rr_lane[k]) begin
            expect_ev(EV_GRANT, rr_lane[k], 0);
            expect_ev(EV_DONE, rr_lane[k], 0);
        end
        req = 4'hF;
        foreach (rr_lane[k]) begin
            run_frame(rr_lane[k], 16'h0000, waited, beats);
            check("rr frame length", beats, FL);
            check("rr non-RUN cycles before grant", waited, (k == 0) ? 1 : 2);
        end

        // Count wrap on lane 2 alone (ptr is 1 here).
        req = 4'b0100;
        expect_ev(EV_GRANT, 2, 0);
        expect_ev(EV_DONE, 2, 0);
        run_frame(2, 16'h00FF, waited, beats);
        check("wrap frame length", beats, FL);
        check("wrap frame_done", int'(frame_done), 1);
        check("wrap done_id", int'(done_id), 2);
        check("wrap final ones_cnt", int'(ones_cnt), 0);

        // Pointer fairness: lane 3, then 1001 -> lane 0, then lane 3.
        req = 4'b1000;
        expect_ev(EV_GRANT, 3, 0);
        expect_ev(EV_DONE, 3, 3);
        run_frame(3, 16'h0007, waited, beats);
        check("lane3 frame length", beats, FL);
        req = 4'b1001;
        expect_ev(EV_GRANT, 0, 0);
        expect_ev(EV_DONE, 0, 0);
        expect_ev(EV_GRANT, 3, 0);
        expect_ev(EV_DONE, 3, 0);
        run_frame(0, 16'h0000, waited, beats);
        check("fair lane0 gap", waited, 2);
        run_frame(3, 16'h0000, waited, beats);
        check("fair lane3 length", beats, FL);
        req = 4'b0;

        // Reset at beat 4 of a lane-1 frame (ptr becomes 2 at grant).
        req    = 4'b0010;
        bit_in = 4'b0;
        expect_ev(EV_GRANT, 1, 0);
        wait_busy(waited);
        @(negedge clk);
        bit_in = 4'b0010;
        repeat (3) @(negedge clk);
        check("pre-reset ones_cnt", int'(ones_cnt), 3);
        reset = 1'b1;
        #1;
        check("busy low in reset", int'(busy), 0);
        check("ser_out low in reset", int'(ser_out), 0);
        @(negedge clk);
        check("post-reset gnt", int'(gnt), 0);
        check("post-reset busy", int'(busy), 0);
        check("post-reset ones_cnt", int'(ones_cnt), 0);
        check("post-reset done_id", int'(done_id), 0);
        check("post-reset frame_done", int'(frame_done), 0);
        check("post-reset abort", int'(abort), 0);
        reset  = 1'b0;
        req    = 4'b0110;
        bit_in = 4'b0;
        expect_ev(EV_GRANT, 1, 0);
        expect_ev(EV_DONE, 1, 0);
        run_frame(1, 16'h0000, waited, beats);
        check("post-reset frame length", beats, FL);
        req = 4'b0;

        // Lane 1 drops its request at beat 3.
        req    = 4'b0010;
        bit_in = 4'hF;
`ifdef BIT_STREAM_ARBITER_ABORT_EN
        expect_ev(EV_GRANT, 1, 0);
        expect_ev(EV_ABORT, 1, 3);
        wait_busy(waited);
        repeat (3) @(negedge clk);
        check("abort beat3 ones_cnt", int'(ones_cnt), 3);
        req = 4'b0;
        #1;
        check("abort ser_out forced 0", int'(ser_out), 0);
        @(negedge clk);
        check("abort pulse", int'(abort), 1);
        check("abort no frame_done", int'(frame_done), 0);
        check("abort done_id", int'(done_id), 1);
        check("abort ones_cnt held", int'(ones_cnt), 3);
        check("abort busy", int'(busy), 0);
`else
        expect_ev(EV_GRANT, 1, 0);
        expect_ev(EV_DONE, 1, 0);
        wait_busy(waited);
        beats = 0;
        while (busy && beats < 20) begin
            if (beats == 3) begin
                req = 4'b0;
                #1;
                check("no-abort ser_out follows bit", int'(ser_out), 1);
            end
            @(negedge clk);
            beats++;
        end
        check("no-abort frame length", beats, FL);
        check("no-abort frame_done", int'(frame_done), 1);
        check("no-abort abort low", int'(abort), 0);
`endif
        req = 4'b0;

        repeat (4) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
